timer_arbiter: RTL

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter_pkg.sv | 15 +
 rtl/timer_arbiter_rr.sv | 24 ++
 rtl/timer_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared FSM encoding and default parameters for the timer arbiter.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_COUNT_WIDTH   = 32;
  localparam int DEF_TIMEOUT_SLACK = 16;

endpackage

// File: rtl/timer_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, one-hot.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] sel
);

  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && req[IDX_W'((int'(last_grant) + off) % NUM_REQ)]) begin
        sel[IDX_W'((int'(last_grant) + off) % NUM_REQ)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one hardware timer among NUM_REQ requesters with round-robin grants.
// Optional watchdog enabled by defining TIMER_ARBITER_TIMEOUT_EN.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int TIMEOUT_SLACK = DEF_TIMEOUT_SLACK
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           fault,
  output logic [COUNT_WIDTH-1:0]         timer_count,
  output logic                           timer_enable,
  input  logic                           timer_interrupt,
  output logic                           timer_interrupt_clear
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d, done_q, done_d, sel;
  logic [COUNT_WIDTH-1:0] tcount_q, tcount_d, sel_count;
  logic [IDX_W-1:0]       last_q, last_d, sel_idx;
  logic                   ten_q, ten_d, clr_q, clr_d;
  logic                   owner_req, cnt_zero, tmo_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .last_grant (last_q),
    .sel        (sel)
  );

  always_comb begin
    sel_count = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_count = req_count[i*COUNT_WIDTH +: COUNT_WIDTH];
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign owner_req = |(req & grant_q);
  assign cnt_zero  = (tcount_q == '0);

`ifdef TIMER_ARBITER_TIMEOUT_EN
  logic [COUNT_WIDTH:0] tmo_q;
  logic                 fault_q;

  // Counter is cleared on every IDLE cycle, so it starts at zero on RUN entry.
  assign tmo_hit = (state_q == ST_RUN) && !cnt_zero && !timer_interrupt &&
                   ((tmo_q + (COUNT_WIDTH+1)'(1)) ==
                    ({1'b0, tcount_q} + (COUNT_WIDTH+1)'(TIMEOUT_SLACK)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= tmo_hit;
      if (state_q == ST_RUN) tmo_q <= tmo_q + (COUNT_WIDTH+1)'(1);
      else                   tmo_q <= '0;
    end
  end

  assign fault = fault_q;
`else
  assign tmo_hit = 1'b0;
  assign fault   = 1'b0;
`endif

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      tcount_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      ten_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tcount_q <= tcount_d;
      last_q   <= last_d;
      ten_q    <= ten_d;
      clr_q    <= clr_d;
    end
  end

  // Next-state logic; completion takes priority over timeout and abort
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req) state_d = ST_RUN;
      ST_RUN: begin
        if (cnt_zero)             state_d = ST_IDLE;
        else if (timer_interrupt) state_d = ST_CLEAR;
        else if (tmo_hit)         state_d = ST_DRAIN;
        else if (!owner_req)      state_d = ST_DRAIN;
      end
      ST_CLEAR, ST_DRAIN: if (!timer_interrupt) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register next values for the outputs
  always_comb begin
    grant_d  = grant_q;
    done_d   = '0;
    tcount_d = tcount_q;
    last_d   = last_q;
    ten_d    = ten_q;
    clr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = sel;
        if (|req) begin
          tcount_d = sel_count;
          last_d   = sel_idx;
          ten_d    = (sel_count != '0);
        end
      end
      ST_RUN: begin
        // Zero count keeps grant through the done cycle; IDLE reloads it.
        if (cnt_zero) begin
          done_d = grant_q;
        end else if (timer_interrupt) begin
          done_d = grant_q;
          ten_d  = 1'b0;
          clr_d  = 1'b1;
        end else if (tmo_hit || !owner_req) begin
          ten_d  = 1'b0;
          clr_d  = 1'b1;
        end
      end
      ST_CLEAR, ST_DRAIN: if (!timer_interrupt) grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  assign busy                  = (state_q != ST_IDLE);
  assign grant                 = grant_q;
  assign done                  = done_q;
  assign timer_count           = tcount_q;
  assign timer_enable          = ten_q;
  assign timer_interrupt_clear = clr_q;

endmodule
